// File: rtl/exec_pkg.sv
// Shared definitions for the execute datapath: opcodes, store-FSM states and
// command-bundle sizing.
package exec_pkg;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_NOTA  = 4'd5;
   localparam logic [3:0] OP_SHL   = 4'd6;
   localparam logic [3:0] OP_SHR   = 4'd7;
   localparam logic [3:0] OP_PASSB = 4'd8;
   localparam logic [3:0] OP_NOP   = 4'b1111;

   typedef enum logic [1:0] {
      WR_IDLE  = 2'd0,
      WR_ARMED = 2'd1,
      WR_DONE  = 2'd2
   } wr_state_t;

   // opcode(4) + sel1 + sel3 + w_r
   localparam int CMD_CTRL_W = 7;

   function automatic int cmd_width(input int dw);
      return 3 * dw + CMD_CTRL_W;
   endfunction

endpackage

// File: rtl/dp_dmem.sv
// Data memory: synchronous read (read-before-write), synchronous write,
// synchronous clear of every word and of the read register.
module dp_dmem #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 5
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  we,
   input  logic [ADDR_BITS-1:0]  addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_BITS;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rdata <= '0;
      end else begin
         rdata <= mem[addr];
         if (we) begin
            mem[addr] <= wdata;
         end
      end
   end

endmodule

// File: rtl/exec_datapath.sv
// Execute datapath: registered ALU, data memory and one-shot store FSM.
// Optional macro EXEC_DATAPATH_FLAGS_EN adds registered zero/carry flags.
//
// state    | meaning
// WR_IDLE  | no store pending
// WR_ARMED | store seen; alu_out holds its address, write once bundle is stable
// WR_DONE  | write performed; wait for the command to change
module exec_datapath
   import exec_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] operand1,
   input  logic [DATA_WIDTH-1:0] operand2,
   input  logic [DATA_WIDTH-1:0] offset,
   input  logic [3:0]            opcode,
   input  logic                  sel1,
   input  logic                  sel3,
   input  logic                  w_r,
`ifdef EXEC_DATAPATH_FLAGS_EN
   output logic                  zero_flag,
   output logic                  carry_flag,
`endif
   output logic [DATA_WIDTH-1:0] result2
);

   localparam int CMD_W = cmd_width(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] alu_b;
   logic [DATA_WIDTH:0]   alu_res;
   logic [DATA_WIDTH-1:0] alu_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic [CMD_W-1:0]      bundle;
   logic [CMD_W-1:0]      cmd_q;
   logic                  chg;
   logic                  mem_we;
   wr_state_t             state;

   assign alu_b = sel3 ? offset : operand2;

   // Bit DATA_WIDTH carries the carry/borrow or the bit shifted out.
   always_comb begin
      alu_res = '0;
      case (opcode)
         OP_ADD:   alu_res = {1'b0, operand1} + {1'b0, alu_b};
         OP_SUB:   alu_res = {1'b0, operand1} - {1'b0, alu_b};
         OP_AND:   alu_res = {1'b0, operand1 & alu_b};
         OP_OR:    alu_res = {1'b0, operand1 | alu_b};
         OP_XOR:   alu_res = {1'b0, operand1 ^ alu_b};
         OP_NOTA:  alu_res = {1'b0, ~operand1};
         OP_SHL:   alu_res = {operand1, 1'b0};
         OP_SHR:   alu_res = {operand1[0], 1'b0, operand1[DATA_WIDTH-1:1]};
         OP_PASSB: alu_res = {1'b0, alu_b};
         default:  alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_out <= '0;
      end else if (opcode != OP_NOP) begin
         alu_out <= alu_res[DATA_WIDTH-1:0];
      end
   end

`ifdef EXEC_DATAPATH_FLAGS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_flag  <= 1'b0;
         carry_flag <= 1'b0;
      end else if (opcode != OP_NOP) begin
         zero_flag  <= (alu_res[DATA_WIDTH-1:0] == '0);
         carry_flag <= alu_res[DATA_WIDTH];
      end
   end
`endif

   assign bundle = {operand1, operand2, offset, opcode, sel1, sel3, w_r};
   assign chg    = (bundle != cmd_q);
   assign mem_we = (state == WR_ARMED) && !chg;

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_q <= '0;
         state <= WR_IDLE;
      end else begin
         cmd_q <= bundle;
         case (state)
            WR_IDLE: begin
               if (w_r) state <= WR_ARMED;
            end
            WR_ARMED: begin
               if (chg) state <= w_r ? WR_ARMED : WR_IDLE;
               else     state <= WR_DONE;
            end
            WR_DONE: begin
               if (chg) state <= w_r ? WR_ARMED : WR_IDLE;
            end
            default: state <= WR_IDLE;
         endcase
      end
   end

   dp_dmem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (ADDR_BITS)
   ) u_dmem (
      .clk   (clk),
      .clr   (rst),
      .we    (mem_we),
      .addr  (alu_out[ADDR_BITS-1:0]),
      .wdata (operand2),
      .rdata (data_out)
   );

   assign result2 = sel1 ? alu_out : data_out;

endmodule

// File: tb/tb_exec_datapath.sv
// Directed-vector bench for exec_datapath; flag checks compile in when
// EXEC_DATAPATH_FLAGS_EN is defined.
module tb_exec_datapath;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] operand1, operand2, offset;
   logic [3:0] opcode;
   logic       sel1, sel3, w_r;
   logic [7:0] result2;
`ifdef EXEC_DATAPATH_FLAGS_EN
   logic       zero_flag, carry_flag;
`endif

   int n_vec = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int base;

   always #5 clk = ~clk;

   exec_datapath dut (
      .clk        (clk),
      .rst        (rst),
      .operand1   (operand1),
      .operand2   (operand2),
      .offset     (offset),
      .opcode     (opcode),
      .sel1       (sel1),
      .sel3       (sel3),
      .w_r        (w_r),
`ifdef EXEC_DATAPATH_FLAGS_EN
      .zero_flag  (zero_flag),
      .carry_flag (carry_flag),
`endif
      .result2    (result2)
   );

   // Write strobe is stable mid-cycle; it commits on the following edge.
   always @(negedge clk) begin
      if (dut.mem_we === 1'b1 && rst === 1'b0) wr_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] off,
                      input logic [3:0] op, input logic s1, input logic s3, input logic wr);
      operand1 = a; operand2 = b; offset = off;
      opcode = op; sel1 = s1; sel3 = s3; w_r = wr;
   endtask

   typedef struct {
      string      tag;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] off;
      logic [3:0] op;
      logic       s3;
      logic [7:0] exp;
   } alu_vec_t;

   alu_vec_t alu_tbl[$];

   initial begin
      alu_tbl.push_back('{"add",     8'd2,   8'd3,   8'h00, 4'd0,  1'b0, 8'd5});
      alu_tbl.push_back('{"sub",     8'd2,   8'd3,   8'h00, 4'd1,  1'b0, 8'hFF});
      alu_tbl.push_back('{"and",     8'hF0,  8'h3C,  8'h00, 4'd2,  1'b0, 8'h30});
      alu_tbl.push_back('{"or",      8'hF0,  8'h3C,  8'h00, 4'd3,  1'b0, 8'hFC});
      alu_tbl.push_back('{"xor",     8'hF0,  8'h3C,  8'h00, 4'd4,  1'b0, 8'hCC});
      alu_tbl.push_back('{"nota",    8'hF0,  8'h3C,  8'h00, 4'd5,  1'b0, 8'h0F});
      alu_tbl.push_back('{"shl",     8'hF0,  8'h3C,  8'h00, 4'd6,  1'b0, 8'hE0});
      alu_tbl.push_back('{"shr",     8'hF1,  8'h3C,  8'h00, 4'd7,  1'b0, 8'h78});
      alu_tbl.push_back('{"passb",   8'hF0,  8'h3C,  8'h00, 4'd8,  1'b0, 8'h3C});
      alu_tbl.push_back('{"op9",     8'hF0,  8'h3C,  8'h00, 4'd9,  1'b0, 8'h00});
      alu_tbl.push_back('{"op14",    8'hF0,  8'h3C,  8'h00, 4'd14, 1'b0, 8'h00});
      alu_tbl.push_back('{"add_off", 8'hF0,  8'h3C,  8'h20, 4'd0,  1'b1, 8'h10});
      alu_tbl.push_back('{"passoff", 8'h00,  8'h3C,  8'h99, 4'd8,  1'b1, 8'h99});

      rst = 1'b1;
      cmd(8'h00, 8'h00, 8'h00, 4'hF, 1'b1, 1'b0, 1'b0);
      step(2);
      chk("rst_alu", result2, 8'h00);
      sel1 = 1'b0;
      #1;
      chk("rst_mem", result2, 8'h00);
      rst = 1'b0;

      foreach (alu_tbl[i]) begin
         cmd(alu_tbl[i].a, alu_tbl[i].b, alu_tbl[i].off, alu_tbl[i].op, 1'b1, alu_tbl[i].s3, 1'b0);
         step(1);
         chk(alu_tbl[i].tag, result2, alu_tbl[i].exp);
      end

      cmd(8'd2, 8'd3, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
      step(1);
      chk("nop_pre", result2, 8'd5);
      opcode = 4'hF;
      step(2);
      chk("nop_hold", result2, 8'd5);

      // store 3 to address 1+4
      base = wr_cnt;
      cmd(8'd1, 8'd3, 8'd4, 4'd0, 1'b0, 1'b1, 1'b1);
      step(1);
      chk("st_wr_e1", wr_cnt - base, 0);
      step(1);
      chk("st_wr_e2", wr_cnt - base, 1);
      step(2);
      chk("st_wr_e4", wr_cnt - base, 1);
      w_r = 1'b0;
      step(2);
      chk("ld_5", result2, 8'd3);

      // address wrap: 30+5 -> 3
      base = wr_cnt;
      cmd(8'd30, 8'hA5, 8'd5, 4'd0, 1'b0, 1'b1, 1'b1);
      step(4);
      chk("wrap_wr", wr_cnt - base, 1);
      w_r = 1'b0;
      step(2);
      chk("ld_3", result2, 8'hA5);
      cmd(8'd30, 8'h00, 8'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      step(2);
      chk("ld_30", result2, 8'h00);
      operand1 = 8'd31;
      step(2);
      chk("ld_31", result2, 8'h00);

      // bundle changes while armed
      base = wr_cnt;
      cmd(8'd1, 8'h77, 8'd4, 4'd0, 1'b0, 1'b1, 1'b1);
      step(1);
      chk("chg_wr_e1", wr_cnt - base, 0);
      operand1 = 8'd2;
      step(1);
      chk("chg_wr_e2", wr_cnt - base, 0);
      step(1);
      chk("chg_wr_e3", wr_cnt - base, 1);
      step(1);
      chk("chg_wr_e4", wr_cnt - base, 1);
      cmd(8'd1, 8'h00, 8'd4, 4'd0, 1'b0, 1'b1, 1'b0);
      step(2);
      chk("chg_ld_5", result2, 8'd3);
      operand1 = 8'd2;
      step(2);
      chk("chg_ld_6", result2, 8'h77);

      // reset while armed
      base = wr_cnt;
      cmd(8'd1, 8'h5A, 8'd9, 4'd0, 1'b0, 1'b1, 1'b1);
      step(1);
      rst = 1'b1;
      step(1);
      chk("rst_arm_r2", result2, 8'h00);
      chk("rst_arm_wr", wr_cnt - base, 0);
      rst = 1'b0;
      cmd(8'd1, 8'h00, 8'd9, 4'd0, 1'b0, 1'b1, 1'b0);
      step(2);
      chk("rst_ld_10", result2, 8'h00);
      operand1 = 8'd2;
      step(2);
      chk("rst_ld_6", result2, 8'h00);
      chk("rst_no_wr", wr_cnt - base, 0);

`ifdef EXEC_DATAPATH_FLAGS_EN
      cmd(8'hFF, 8'h01, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
      step(1);
      chk("fl_add_r", result2, 8'h00);
      chk("fl_add_z", zero_flag, 1'b1);
      chk("fl_add_c", carry_flag, 1'b1);
      cmd(8'h01, 8'h00, 8'h00, 4'd7, 1'b1, 1'b0, 1'b0);
      step(1);
      chk("fl_shr_r", result2, 8'h00);
      chk("fl_shr_c", carry_flag, 1'b1);
      cmd(8'h03, 8'h01, 8'h00, 4'd2, 1'b1, 1'b0, 1'b0);
      step(1);
      chk("fl_and_z", zero_flag, 1'b0);
      chk("fl_and_c", carry_flag, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/exec_datapath.md
Name: exec_datapath

Overview:
- Responder side of the CU command interface.
- Consumes operand1/operand2/offset/opcode/sel1/sel3/w_r and contains the 8-bit ALU and the DATA_WIDTH x 2^ADDR_BITS data memory. Drives result2 back to the CU for write-back.
- Timing matches the CU FSM: std_op results are valid at the CU WRITE_BACK edge; loadR data is valid one edge later.

Parameters:
- DATA_WIDTH, 8, operand/result/memory word width.
- ADDR_BITS, 5, data memory address bits (32 words).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- operand1  in  DATA_WIDTH  ALU operand A (X2).
- operand2  in  DATA_WIDTH  ALU operand B (X3), or store data (z).
- offset  in  DATA_WIDTH  immediate; replaces operand B when sel3=1.
- opcode  in  4  ALU operation; 4'b1111 = NOP.
- sel1  in  1  result2 source: 1 = ALU result, 0 = memory read data.
- sel3  in  1  ALU B source: 1 = offset, 0 = operand2.
- w_r  in  1  1 = store command asserted.
- result2  out  DATA_WIDTH  write-back data to the CU.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: alu_out=0, data_out=0, cmd_q=0, write FSM=IDLE, all memory words cleared to 0. result2=0 after reset, since it is a mux of zeroed registers.

ALU (registered, 1 cycle):
- B = sel3 ? offset : operand2.
- alu_out <= f(operand1, B) on every edge, except NOP, where alu_out holds.
- Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by 1, 7 SHR A by 1 (logical), 8 PASS B. Codes 9-14 produce 0.
- All arithmetic is modulo 2^DATA_WIDTH (wraps, no saturation).

Memory:
- Address = alu_out[ADDR_BITS-1:0]. Upper bits are ignored, so addresses wrap modulo 32.
- Memory ops must use opcode ADD, giving address = operand1+offset.
- Read is synchronous: data_out <= mem[addr] on every edge.
- result2 = sel1 ? alu_out : data_out (combinational mux of registers).
- Latency from command inputs: std_op result valid after 1 edge; load data valid after 2 edges.

Store write FSM (exactly one write per store command):
- Bundle = {operand1, operand2, offset, opcode, sel1, sel3, w_r}; cmd_q <= bundle every edge; chg = (bundle != cmd_q).
- IDLE: w_r=1 -> ARMED (alu_out now computed from this bundle); else stay.
- ARMED: chg=1 -> (w_r ? ARMED : IDLE), no write. chg=0 -> mem[addr] <= operand2, -> DONE.
- DONE: chg=1 -> (w_r ? ARMED : IDLE); else hold, no further writes.
- A store therefore writes 2 edges after the command appears, provided the command is held stable. The CU holds it for 4 edges.
- Back-to-back identical store bundles perform one write. The result is identical, so this is acceptable.
- Read and write to the same address on the same edge: data_out returns the old value (read-before-write).

Reset mid-operation:
- A pending ARMED write is discarded.
- Memory is cleared.
- The FSM restarts in IDLE on the next edge with rst=0.

Optional Feature:
- Macro: EXEC_DATAPATH_FLAGS_EN.
- Defined: adds outputs zero_flag (1) and carry_flag (1), both registered alongside alu_out and both reset to 0.
  - zero_flag = (ALU result == 0).
  - carry_flag = carry-out of ADD, borrow of SUB, or the bit shifted out for SHL/SHR; 0 for other opcodes.
  - On NOP both flags hold.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package exec_pkg:
  - opcode localparams (OP_ADD..OP_PASSB, OP_NOP=4'b1111);
  - write-FSM state encodings (WR_IDLE, WR_ARMED, WR_DONE);
  - command-bundle width constant.
- One sub-module, dp_dmem: synchronous-read, synchronous-write RAM with sync clear, parameterised by DATA_WIDTH/ADDR_BITS.
- ALU and FSM stay inline in exec_datapath.

Test Plan:
1. ADD: operand1=2, operand2=3, opcode=0, sel1=1, sel3=0 held -> result2=8'd5 after 1 edge. SUB with 2,3 -> 8'hFF.
2. Store, then load:
   - Store: operand1=1, offset=4, operand2=3, opcode=0, sel3=1, sel1=0, w_r=1 held 4 edges -> mem[5]=3, exactly one write strobe (on edge 2).
   - Load: same command with w_r=0 -> result2=3 after 2 edges.
3. Address wrap: operand1=30, offset=5, store operand2=8'hA5 -> mem[3]=8'hA5; mem[30] and mem[31] unchanged.
4. Bundle change while ARMED: store to addr 5 held 1 edge, then operand1 changes to 2 (w_r still 1) -> no write to mem[5]; mem[6] written 2 edges after the change.
5. NOP and reset:
   - After ADD gives result2=5, opcode=4'b1111 -> result2 stays 5.
   - Assert rst during ARMED -> result2=0, no write, mem[addr] reads 0 afterwards.
6. With EXEC_DATAPATH_FLAGS_EN defined: ADD 8'hFF + 8'h01 -> result2=0, zero_flag=1, carry_flag=1; SHR of 8'h01 -> result2=0, carry_flag=1.
